// File: rtl/store64_unit.sv
// Store64 unit: writes a 64-bit operand (two 32-bit source registers) to memory
// as two 32-bit OBI write beats. Reports completion and misalignment to dispatch.
module store64_unit #(
    parameter bit PIPELINED = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] addr_i,
    input  logic [31:0] rs1_0_i,
    input  logic [31:0] rs2_0_i,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    output logic        done_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        IDLE,
        REQ_LO,
        WAIT_LO,
        REQ_HI,
        WAIT_RSP
    } state_e;

    state_e      state;
    logic [31:0] hi_q;
    logic [1:0]  outstanding;
    logic [1:0]  outstanding_d;
    logic        accept;
    logic        gnt_hit;
    logic        rsp_hit;

    assign accept  = valid_i && ready_o;
    assign gnt_hit = data_req_o && data_gnt_i;
    // A response with nothing outstanding (e.g. a leftover from before reset) is dropped.
    assign rsp_hit = data_rvalid_i && (outstanding != 2'd0);

    // Write-only port: enables follow the request flop directly.
    assign data_we_o = data_req_o;
    assign data_be_o = {4{data_req_o}};

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        outstanding_d = outstanding;
        if (gnt_hit && !rsp_hit) begin
            outstanding_d = outstanding + 2'd1;
        end else if (rsp_hit && !gnt_hit) begin
            outstanding_d = outstanding - 2'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            ready_o      <= 1'b1;
            data_req_o   <= 1'b0;
            data_addr_o  <= '0;
            data_wdata_o <= '0;
            hi_q         <= '0;
            outstanding  <= '0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            outstanding <= outstanding_d;

            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (addr_i[1:0] != 2'b00) begin
                            err_o <= 1'b1;
                        end else begin
                            state        <= REQ_LO;
                            ready_o      <= 1'b0;
                            data_req_o   <= 1'b1;
                            data_addr_o  <= addr_i;
                            data_wdata_o <= rs1_0_i;
                            hi_q         <= rs2_0_i;
                        end
                    end
                end

                REQ_LO: begin
                    if (data_gnt_i) begin
                        if (PIPELINED) begin
                            // Keep req high: the high beat goes out right behind the low one.
                            state        <= REQ_HI;
                            data_addr_o  <= data_addr_o + 32'd4;
                            data_wdata_o <= hi_q;
                        end else begin
                            state      <= WAIT_LO;
                            data_req_o <= 1'b0;
                        end
                    end
                end

                WAIT_LO: begin
                    if (rsp_hit) begin
                        state        <= REQ_HI;
                        data_req_o   <= 1'b1;
                        data_addr_o  <= data_addr_o + 32'd4;
                        data_wdata_o <= hi_q;
                    end
                end

                REQ_HI: begin
                    if (data_gnt_i) begin
                        state      <= WAIT_RSP;
                        data_req_o <= 1'b0;
                    end
                end

                WAIT_RSP: begin
                    if (outstanding_d == 2'd0) begin
                        state   <= IDLE;
                        ready_o <= 1'b1;
                        done_o  <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    // A stalled request keeps its payload frozen until the grant arrives.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        (data_req_o && !data_gnt_i) |=> (data_req_o && $stable(data_addr_o) && $stable(data_wdata_o)));

endmodule

// File: tb/tb_store64_unit.sv
// Scoreboard bench for store64_unit: instance 0 is PIPELINED=0, instance 1 is PIPELINED=1.
// Both share dispatch stimulus; each has its own bus responder, memory and expectation queues.
module tb_store64_unit;

    localparam int N = 2;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    typedef struct packed {
        logic       is_err;
        logic [7:0] lat;     // 0 = latency not checked
    } ev_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] addr  = '0;
    logic [31:0] lo    = '0;
    logic [31:0] hi    = '0;

    logic [N-1:0] ready;
    logic [N-1:0] req;
    logic [N-1:0] gnt    = '0;
    logic [N-1:0] rvalid = '0;
    logic [N-1:0] we;
    logic [N-1:0] done;
    logic [N-1:0] err;
    logic [31:0]  daddr  [N];
    logic [31:0]  dwdata [N];
    logic [3:0]   be     [N];

    beat_t beat_q [N][$];
    ev_t   ev_q   [N][$];

    int checks  = 0;
    int errors  = 0;
    int ncyc    = 0;
    int acc_cyc = 0;
    int stall_n = 0;
    int rsp_lat = 1;

    int          stall_left [N];
    bit          in_beat    [N];
    logic [31:0] hold_a     [N];
    logic [31:0] hold_d     [N];
    int          due        [N][2];
    int          ndue       [N];
    int          grants     [N];
    int          dones      [N];
    int          errs       [N];
    logic [7:0]  mem [logic [32:0]];

    always #5 clk = ~clk;

    store64_unit #(.PIPELINED(1'b0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .valid_i(valid), .ready_o(ready[0]),
        .addr_i(addr), .rs1_0_i(lo), .rs2_0_i(hi),
        .data_req_o(req[0]), .data_gnt_i(gnt[0]), .data_rvalid_i(rvalid[0]),
        .data_addr_o(daddr[0]), .data_we_o(we[0]), .data_be_o(be[0]),
        .data_wdata_o(dwdata[0]), .done_o(done[0]), .err_o(err[0])
    );

    store64_unit #(.PIPELINED(1'b1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .valid_i(valid), .ready_o(ready[1]),
        .addr_i(addr), .rs1_0_i(lo), .rs2_0_i(hi),
        .data_req_o(req[1]), .data_gnt_i(gnt[1]), .data_rvalid_i(rvalid[1]),
        .data_addr_o(daddr[1]), .data_we_o(we[1]), .data_be_o(be[1]),
        .data_wdata_o(dwdata[1]), .done_o(done[1]), .err_o(err[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: actual %s required none", name, what);
    endtask

    function automatic logic [31:0] rd_word(input int i, input logic [31:0] a);
        logic [31:0] w;
        for (int b = 0; b < 4; b++) begin
            w[8*b +: 8] = mem[{i[0], a + 32'(b)}];
        end
        return w;
    endfunction

    // Bus responder + monitor: drives gnt/rvalid and pops the scoreboard on every DUT event.
    always @(negedge clk) begin
        ncyc++;
        for (int i = 0; i < N; i++) begin
            rvalid[i] = 1'b0;
            if (ndue[i] > 0 && due[i][0] <= ncyc) begin
                rvalid[i] = 1'b1;
                due[i][0] = due[i][1];
                ndue[i]--;
            end
            if (!rst_n) begin
                gnt[i]     = 1'b0;
                in_beat[i] = 1'b0;
            end else begin
                if (req[i]) begin
                    check($sformatf("we_be_active%0d", i), {we[i], be[i]}, 5'h1F);
                    if (!in_beat[i]) begin
                        in_beat[i]    = 1'b1;
                        stall_left[i] = stall_n;
                        hold_a[i]     = daddr[i];
                        hold_d[i]     = dwdata[i];
                    end else begin
                        check($sformatf("stall_addr%0d", i), daddr[i], hold_a[i]);
                        check($sformatf("stall_wdata%0d", i), dwdata[i], hold_d[i]);
                    end
                    if (stall_left[i] > 0) begin
                        gnt[i] = 1'b0;
                        stall_left[i]--;
                    end else begin
                        gnt[i]     = 1'b1;
                        in_beat[i] = 1'b0;
                        grants[i]++;
                        if (ndue[i] < 2) begin
                            due[i][ndue[i]] = ncyc + rsp_lat;
                            ndue[i]++;
                        end
                        for (int b = 0; b < 4; b++) begin
                            mem[{i[0], daddr[i] + 32'(b)}] = dwdata[i][8*b +: 8];
                        end
                        if (beat_q[i].size() == 0) begin
                            fail($sformatf("unexpected_beat%0d", i), $sformatf("beat @0x%0h", daddr[i]));
                        end else begin
                            beat_t eb;
                            eb = beat_q[i].pop_front();
                            check($sformatf("beat_addr%0d", i), daddr[i], eb.addr);
                            check($sformatf("beat_wdata%0d", i), dwdata[i], eb.data);
                        end
                    end
                end else begin
                    gnt[i] = 1'b0;
                    check($sformatf("we_be_idle%0d", i), {we[i], be[i]}, 5'h00);
                    if (in_beat[i]) begin
                        fail($sformatf("req_drop%0d", i), "req withdrawn before grant");
                        in_beat[i] = 1'b0;
                    end
                end
                if (done[i] || err[i]) begin
                    dones[i] += int'(done[i]);
                    errs[i]  += int'(err[i]);
                    if (ev_q[i].size() == 0) begin
                        fail($sformatf("unexpected_event%0d", i), $sformatf("done=%0b err=%0b", done[i], err[i]));
                    end else begin
                        ev_t ee;
                        ee = ev_q[i].pop_front();
                        check($sformatf("event_kind%0d", i), {done[i], err[i]}, {~ee.is_err, ee.is_err});
                        if (ee.lat != 8'd0) begin
                            check($sformatf("latency%0d", i), 64'(ncyc - acc_cyc), 64'(ee.lat));
                        end
                    end
                end
            end
        end
    end

    task automatic check_reset(input string tag);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s_ready%0d", tag, i), ready[i], 1'b1);
            check($sformatf("%s_req%0d", tag, i), {req[i], we[i], be[i]}, 6'h00);
            check($sformatf("%s_addr%0d", tag, i), daddr[i], 32'h0);
            check($sformatf("%s_wdata%0d", tag, i), dwdata[i], 32'h0);
            check($sformatf("%s_done_err%0d", tag, i), {done[i], err[i]}, 2'b00);
        end
    endtask

    // Drives one request; the inputs are scrambled right after the accept edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] l, input logic [31:0] h,
                         input logic [31:0] hi_addr, input int lat0, input int lat1);
        ev_t   e;
        beat_t b;
        @(negedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (a[1:0] != 2'b00) begin
                e.is_err = 1'b1;
                e.lat    = 8'd1;
            end else begin
                b.addr = a;       b.data = l; beat_q[i].push_back(b);
                b.addr = hi_addr; b.data = h; beat_q[i].push_back(b);
                e.is_err = 1'b0;
                e.lat    = 8'((i == 0) ? lat0 : lat1);
            end
            ev_q[i].push_back(e);
        end
        check("ready_at_issue", ready, 2'b11);
        valid   = 1'b1;
        addr    = a;
        lo      = l;
        hi      = h;
        acc_cyc = ncyc;
        @(posedge clk);
        #1;
        valid = 1'b0;
        addr  = $urandom;
        lo    = $urandom;
        hi    = $urandom;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((ev_q[0].size() + ev_q[1].size() + beat_q[0].size() + beat_q[1].size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, 64'(ev_q[0].size() + ev_q[1].size() + beat_q[0].size() + beat_q[1].size()), 64'd0);
        @(negedge clk);
        #1;
        check({name, "_ready"}, ready, 2'b11);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0 [N];
        int d0 [N];
        for (int i = 0; i < N; i++) begin
            stall_left[i] = 0;
            in_beat[i]    = 1'b0;
            ndue[i]       = 0;
            grants[i]     = 0;
            dones[i]      = 0;
            errs[i]       = 0;
        end

        #7;
        check_reset("reset");
        #16;
        rst_n = 1'b1;

        // Aligned store on a zero-wait bus, with memory round trip.
        issue(32'h0000_1000, 32'h0302_0100, 32'h0706_0504, 32'h0000_1004, 5, 4);
        wait_idle("aligned");
        for (int i = 0; i < N; i++) begin
            check($sformatf("load64_rd2_%0d", i), rd_word(i, 32'h0000_1000), 32'h0302_0100);
            check($sformatf("load64_rd1_%0d", i), rd_word(i, 32'h0000_1004), 32'h0706_0504);
            check($sformatf("mem_byte_1007_%0d", i), mem[{i[0], 32'h0000_1007}], 8'h07);
        end

        // Grant stall of 3 cycles on each beat.
        for (int i = 0; i < N; i++) begin g0[i] = grants[i]; d0[i] = dones[i]; end
        stall_n = 3;
        issue(32'h0000_2000, 32'hCAFE_0001, 32'hBEEF_0002, 32'h0000_2004, 0, 0);
        wait_idle("stall");
        stall_n = 0;
        for (int i = 0; i < N; i++) begin
            check($sformatf("stall_grants%0d", i), 64'(grants[i] - g0[i]), 64'd2);
            check($sformatf("stall_dones%0d", i), 64'(dones[i] - d0[i]), 64'd1);
        end

        // Misaligned request, then an aligned one.
        issue(32'h0000_1002, 32'h1111_1111, 32'h2222_2222, 32'h0000_1006, 0, 0);
        @(negedge clk);
        #1;
        check("misaligned_ready", ready, 2'b11);
        check("misaligned_req", req, 2'b00);
        wait_idle("misaligned");
        issue(32'h0000_1008, 32'h8899_AABB, 32'hCCDD_EEFF, 32'h0000_100C, 5, 4);
        wait_idle("after_misaligned");

        // Address wrap at the top of the address space.
        issue(32'hFFFF_FFFC, 32'h0BAD_F00D, 32'h1234_5678, 32'h0000_0000, 5, 4);
        wait_idle("wrap");

        // Input change right after accept: bus must carry captured values.
        issue(32'h0000_4000, 32'hA5A5_5A5A, 32'h0F0F_F0F0, 32'h0000_4004, 5, 4);
        addr = 32'h0000_4002;
        lo   = 32'hFFFF_FFFF;
        hi   = 32'h0000_0000;
        wait_idle("input_change");

        // Reset while the pipelined instance is in REQ_HI with one response outstanding.
        for (int i = 0; i < N; i++) d0[i] = dones[i];
        stall_n = 3;
        rsp_lat = 4;
        issue(32'h0000_3000, 32'h0101_0101, 32'h0202_0202, 32'h0000_3004, 0, 0);
        while (ncyc < acc_cyc + 6) @(negedge clk);
        #1;
        check("pre_reset_req", req, 2'b10);
        check("pre_reset_hi_addr", daddr[1], 32'h0000_3004);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset("mid_reset");
        for (int i = 0; i < N; i++) begin
            beat_q[i].delete();
            ev_q[i].delete();
        end
        stall_n = 0;
        @(negedge clk);
        #2;
        rst_n   = 1'b1;
        rsp_lat = 1;
        repeat (5) @(negedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            check($sformatf("no_done_after_reset%0d", i), 64'(dones[i] - d0[i]), 64'd0);
        end
        check("post_reset_ready", ready, 2'b11);
        issue(32'h0000_5000, 32'h7654_3210, 32'hFEDC_BA98, 32'h0000_5004, 5, 4);
        wait_idle("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/store64_unit.md
Name: store64_unit

Overview:
- Store-side counterpart of the 64-bit double-register load path in the ATHOS accelerator.
- Takes one 64-bit operand held in two 32-bit source registers (rs1_0 = low word, rs2_0 = high word) plus a base address.
- Issues the operand as two 32-bit write beats on the OBI-style data port toward X-HEEP memory.
- Sits between the ATHOS instruction dispatch (valid/ready) and the memory bus; reports completion and misalignment to dispatch.

Parameters:
- PIPELINED, 1, 1: issue the high beat immediately after the low beat's grant (up to 2 outstanding); 0: issue the high beat only after the low beat's rvalid.

Ports:
- clk_i  input  1  clock, rising-edge
- rst_ni  input  1  asynchronous active-low reset
- valid_i  input  1  dispatch presents a store64 request
- ready_o  output  1  unit accepts a request this cycle
- addr_i  input  32  base byte address
- rs1_0_i  input  32  low word, written at addr_i
- rs2_0_i  input  32  high word, written at addr_i+4
- data_req_o  output  1  bus request
- data_gnt_i  input  1  bus grant
- data_rvalid_i  input  1  write response
- data_addr_o  output  32  beat address
- data_we_o  output  1  write enable, always 1 while data_req_o=1, else 0
- data_be_o  output  4  byte enables, 4'hF while data_req_o=1, else 0
- data_wdata_o  output  32  beat data
- done_o  output  1  one-cycle pulse when both responses are received
- err_o  output  1  one-cycle pulse on a misaligned request

Behaviour:
- Reset values (async, rst_ni=0):
  - ready_o=1; data_req_o=0; data_we_o=0; data_be_o=0.
  - data_addr_o=0; data_wdata_o=0; done_o=0; err_o=0.
  - FSM=IDLE; outstanding counter=0.
  - Reset mid-transfer aborts immediately. Any granted beat whose response arrives after reset is ignored.
- Accept = valid_i && ready_o.
  - On accept, addr_i, rs1_0_i and rs2_0_i are captured into registers; the inputs may change afterwards.
  - ready_o=1 only in IDLE.
- Alignment:
  - If addr_i[1:0]!=0 at accept, err_o pulses the next cycle, there is no bus activity, and the FSM stays in IDLE.
- High-beat address = captured addr + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
- FSM states:
  - IDLE: on an aligned accept, go to REQ_LO.
  - REQ_LO:
    - data_req_o=1, data_addr_o=addr, data_wdata_o=low word.
    - Hold all bus outputs stable until data_gnt_i.
    - On grant, outstanding++.
    - Next state: REQ_HI if PIPELINED=1; WAIT_LO if PIPELINED=0.
  - WAIT_LO (PIPELINED=0 only): data_req_o=0. On data_rvalid_i, outstanding--, go to REQ_HI.
  - REQ_HI:
    - data_req_o=1, data_addr_o=addr+4, data_wdata_o=high word; held until grant.
    - On grant, outstanding++, go to WAIT_RSP.
  - WAIT_RSP: data_req_o=0. When outstanding reaches 0, done_o pulses for 1 cycle and the FSM returns to IDLE.
- Outstanding counter (2 bits):
  - Increments on req&&gnt and decrements on rvalid.
  - Simultaneous gnt and rvalid in the same cycle leaves it unchanged.
  - rvalid with outstanding=0 is ignored; the counter never underflows.
- Completion timing:
  - done_o is asserted the cycle after the final rvalid. ready_o returns to 1 in that same cycle.
  - Minimum latency, PIPELINED=1, gnt same cycle, rvalid next cycle: accept at t0, REQ_LO at t1, REQ_HI at t2, last rvalid at t3, done_o at t4.
- Bus rules:
  - data_req_o never drops without a grant (OBI).
  - Combinational gnt in the same cycle as req is supported.
- No back-to-back accept while busy: dispatch stalls on ready_o=0.

Test Plan:
- Aligned store, zero-wait bus: addr=0x0000_1000, rs1_0=0x03020100, rs2_0=0x07060504 → beat 0x1000/0x03020100, then beat 0x1004/0x07060504, be=F; done_o pulse at t4; memory bytes 0x1000..0x1007 = 00..07 (round-trips through load64 to rd2=0x03020100, rd1=0x07060504).
- Grant stall: hold gnt=0 for 3 cycles on each beat → addr/wdata/req stable through the stall; exactly 2 grants; exactly 1 done_o.
- Misaligned request: addr=0x0000_1002 → err_o pulses once; data_req_o stays 0; ready_o stays 1; a following aligned request completes normally.
- Wrap-around: addr=0xFFFF_FFFC → beats at 0xFFFF_FFFC and 0x0000_0000.
- Input change after accept: change rs1_0/rs2_0/addr the cycle after accept → bus carries the captured values.
- Reset mid-transfer: assert rst_ni=0 during REQ_HI with 1 response outstanding → data_req_o=0 asynchronously and all outputs at reset values. The late rvalid is ignored, no done_o appears, and the next request runs with PIPELINED=0 and PIPELINED=1 both checked.
